reg_arbiter: RTL

Round-robin arbiter and sequencer that shares a single 16-bit storage register between N_REQ requesters. It grants one requester at a time and drives the register's in/load pins. Grant-cycle writes are committed on the following edge. The stored value is broadcast to all requesters as rdata. It sits between CPU-side masters (e.g. A/D-register writers, debug port) and one shared register instance.

---
 rtl/reg_arb_pkg.sv | 17 +
 rtl/reg_arbiter_storage.sv | 15 +
 rtl/reg_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/reg_arb_pkg.sv
// Shared types and constants for the reg_arbiter controller and its testbench.
package reg_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int W_DEF        = 16;
  localparam int N_REQ_DEF    = 4;
  localparam int MAX_LOCK_DEF = 3;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_arbiter_storage.sv
// Existing shared storage register: loads 'in' on a rising edge when 'load' is high, no reset.
module reg_arbiter_storage #(
  parameter int W = 16
) (
  input  logic [W-1:0] in,
  input  logic         load,
  input  logic         clk,
  output logic [W-1:0] out
);

  always_ff @(posedge clk) begin
    if (load) out <= in;
  end

endmodule

// File: rtl/reg_arbiter.sv
// Round-robin arbiter sharing one storage register between N_REQ requesters.
// Optional grant locking is enabled by defining ARB_LOCK_EN.
module reg_arbiter
  import reg_arb_pkg::*;
#(
  parameter  int N_REQ    = N_REQ_DEF,
  parameter  int W        = W_DEF,
  parameter  int MAX_LOCK = MAX_LOCK_DEF,
  localparam int OW       = idx_w(N_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   we,
  input  logic [N_REQ*W-1:0] wdata,
  input  logic [N_REQ-1:0]   lock,
  output logic [N_REQ-1:0]   gnt,
  output logic [OW-1:0]      owner,
  output logic               busy,
  output logic               wr_done,
  output logic [W-1:0]       rdata
);

  arb_state_e     state_q;
  logic [OW-1:0]  owner_q;
  logic [OW-1:0]  rr_ptr_q;
  logic           wr_done_q;
  logic [W-1:0]   wd_arr [N_REQ];
  logic           grant_wr;
  logic           hold;
  logic           reg_load;
  logic [W-1:0]   reg_in;
  logic [W-1:0]   reg_out;
  logic [OW-1:0]  ptr_next;

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign wd_arr[g] = wdata[g*W +: W];
  end

  function automatic logic [OW-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                            input logic [OW-1:0]    ptr);
    logic [OW-1:0] res;
    logic [OW-1:0] idx_v;
    logic          found;
    int            idx;
    res   = ptr;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx   = (int'(ptr) + i) % N_REQ;
      idx_v = OW'(idx);
      if (!found && r[idx_v]) begin
        res   = idx_v;
        found = 1'b1;
      end
    end
    return res;
  endfunction

`ifdef ARB_LOCK_EN
  localparam int CW = $clog2(MAX_LOCK + 1);
  logic [CW-1:0] lock_cnt_q;

  assign hold = req[owner_q] && lock[owner_q] && (lock_cnt_q < CW'(MAX_LOCK));
`else
  logic unused_lock;

  assign hold        = 1'b0;
  assign unused_lock = ^lock ^ (MAX_LOCK < 0);
`endif

  assign grant_wr = (state_q == GRANT) && req[owner_q] && we[owner_q];
  assign ptr_next = (owner_q == OW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

  // Reset forces a load of zero because the storage register has no reset of its own.
  always_comb begin
    reg_load = 1'b1;
    reg_in   = '0;
    if (rst_n) begin
      reg_load = grant_wr;
      reg_in   = wd_arr[owner_q];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      wr_done_q  <= 1'b0;
`ifdef ARB_LOCK_EN
      lock_cnt_q <= '0;
`endif
    end else begin
      wr_done_q <= grant_wr;
      case (state_q)
        IDLE: begin
          if (|req) begin
            owner_q    <= rr_pick(req, rr_ptr_q);
            state_q    <= GRANT;
`ifdef ARB_LOCK_EN
            lock_cnt_q <= CW'(1);
`endif
          end
        end
        GRANT: begin
          if (hold) begin
`ifdef ARB_LOCK_EN
            lock_cnt_q <= lock_cnt_q + 1'b1;
`endif
          end else begin
            state_q  <= IDLE;
            rr_ptr_q <= ptr_next;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  reg_arbiter_storage #(.W(W)) u_reg (
    .in   (reg_in),
    .load (reg_load),
    .clk  (clk),
    .out  (reg_out)
  );

  assign busy    = (state_q == GRANT);
  assign gnt     = busy ? (N_REQ'(1) << owner_q) : '0;
  assign owner   = owner_q;
  assign wr_done = wr_done_q;
  assign rdata   = reg_out;

endmodule
